// File: rtl/bin2bcd_scan.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_scan
// Description : 14-bit binary to 4-digit BCD converter (serial double-dabble)
//               with a multiplexed scanning digit driver.
//               Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value,
    output logic        ready,
    output logic [3:0]  digit,
    output logic [3:0]  dig_sel
);

    localparam int               c_CNT_W   = $clog2(SCAN_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_CONV    = 1'b1;
    localparam logic [3:0]       c_LAST    = 4'd14;

    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_disp [4];
    logic [0:0]         r_state;
    logic [13:0]        r_bin;
    logic [15:0]        r_bcd;
    logic [3:0]         r_iter;

    logic [15:0]        w_adj;
    logic [15:0]        w_commit;
    logic               w_unused;

    // Scan runs free of the converter so the display never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == c_CNT_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // The thousands nibble never exceeds 4 before a shift, so its MSB drops out.
    assign w_unused = w_adj[15];

`ifdef LEAD_ZERO_BLANK_EN
    logic w_blank3;
    logic w_blank2;
    logic w_blank1;

    always_comb begin
        w_blank3 = (r_bcd[15:12] == 4'd0);
        w_blank2 = w_blank3 && (r_bcd[11:8] == 4'd0);
        w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);
        w_commit = {w_blank3 ? 4'hF : r_bcd[15:12],
                    w_blank2 ? 4'hF : r_bcd[11:8],
                    w_blank1 ? 4'hF : r_bcd[7:4],
                    r_bcd[3:0]};
    end
`else
    always_comb begin
        w_commit = r_bcd;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            for (int k = 0; k < 4; k++) begin
                r_disp[k] <= 4'd0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        if (value > 14'd9999) begin
                            for (int k = 0; k < 4; k++) begin
                                r_disp[k] <= 4'd10;
                            end
                        end else begin
                            r_bin   <= value;
                            r_bcd   <= '0;
                            r_iter  <= '0;
                            r_state <= c_CONV;
                        end
                    end
                end
                c_CONV: begin
                    if (r_iter == c_LAST) begin
                        for (int k = 0; k < 4; k++) begin
                            r_disp[k] <= w_commit[4*k +: 4];
                        end
                        r_state <= c_IDLE;
                    end else begin
                        r_bcd  <= {w_adj[14:0], r_bin[13]};
                        r_bin  <= {r_bin[12:0], 1'b0};
                        r_iter <= r_iter + 4'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        ready   = (r_state == c_IDLE);
        digit   = r_disp[r_idx];
        dig_sel = ~(4'b0001 << r_idx);
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_scan.md
BIN2BCD_SCAN -- requirements
Module: bin2bcd_scan

Interface
REQ-001 SHALL have parameter: SCAN_DIV, 50000, clock cycles each digit is held active (legal range 2..2^20).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port: load  input  1  single-cycle strobe; samples value when ready=1.
REQ-005 SHALL have port: value  input  14  unsigned binary number to display (0..9999 valid).
REQ-006 SHALL have port: ready  output  1  high when idle and able to accept load.
REQ-007 SHALL have port: digit  output  4  code for the currently selected digit, feeds the 7-segment decoder bin input; 0-9 numeral, 10 dash, 15 blank.
REQ-008 SHALL have port: dig_sel  output  4  active-low one-cold digit enable; bit0 is the rightmost (ones) digit.

Function
REQ-009 SHALL hold four 4-bit display registers disp[0..3] (ones..thousands); digit SHALL equal disp[idx] and dig_sel SHALL equal ~(4'b0001 << idx), both combinational from registered idx and disp.
REQ-010 SHALL run a scan counter 0..SCAN_DIV-1 continuously; when it is SCAN_DIV-1 it SHALL wrap to 0 and idx SHALL advance 0->1->2->3->0 on the same edge.
REQ-011 Scanning SHALL be independent of conversion; disp changes take effect on the current digit immediately, with no idx or counter restart.
REQ-012 SHALL implement FSM states IDLE and CONV; ready=1 exactly in IDLE.
REQ-013 IDLE, load=1, value<=9999: SHALL capture value, clear BCD accumulator, enter CONV.
REQ-014 IDLE, load=1, value>9999: SHALL write 10 to all four disp registers on that edge and remain IDLE (ready stays 1).
REQ-015 CONV SHALL perform 14 shift-add-3 (double-dabble) iterations, one per clock: each BCD nibble >=5 gets +3, then {bcd, bin} shifts left by 1.
REQ-016 On the edge after the 14th iteration SHALL commit the 16-bit BCD to disp[3:0] and return to IDLE; load edge N -> disp updated and ready=1 after edge N+15.
REQ-017 load asserted while in CONV SHALL be ignored (no queuing, no effect on the running conversion).
REQ-018 Intermediate conversion values SHALL never appear on digit; disp changes only at commit (REQ-016) or overflow (REQ-014).

Reset
REQ-019 On rst=1 at a rising edge: state IDLE, ready=1, scan counter 0, idx 0, disp[0..3]=0, conversion registers 0; hence dig_sel=4'b1110, digit=0.
REQ-020 rst SHALL take priority over load and over an in-progress conversion; an interrupted conversion SHALL be discarded without any commit.

Configuration
REQ-021 Macro LEAD_ZERO_BLANK_EN defined: at commit, each disp[k] (k=3..1) that is 0 and above the most-significant nonzero digit SHALL be written 15 (blank); disp[0] SHALL never be blanked; overflow dashes SHALL be unaffected.
REQ-022 Macro LEAD_ZERO_BLANK_EN undefined: commit SHALL write all four BCD digits unmodified, leading zeros shown as 0.

Verification
REQ-023 Reset: assert rst 2 cycles -> dig_sel=4'b1110, digit=0, ready=1; idx advances after SCAN_DIV cycles.
REQ-024 SCAN_DIV=4, load value=1234 -> ready low 15 cycles then high; digit sequence 4,3,2,1 with dig_sel 1110,1101,1011,0111, each held 4 cycles, repeating.
REQ-025 load value=10000 -> on next cycle all digits read 10, ready never drops.
REQ-026 load 9999, then load 5 at cycle +3 -> committed display 9,9,9,9; 5 is never shown.
REQ-027 load 42 -> with LEAD_ZERO_BLANK_EN digits 2,4,15,15; without, 2,4,0,0; load 0 with macro -> 0,15,15,15.
REQ-028 load 1234, rst at cycle +7 -> reset values per REQ-019, no commit of 1234; a subsequent load 0007 converts correctly.
